// File: rtl/sd_channel_scheduler.sv
// sd_channel_scheduler: round-robin time-multiplexing of one sigma-delta modulator with sinc1 decimation.
// Optional feature macro SD_SCHED_BIPOLAR_EN: result is 2*ones-OSR (two's complement) instead of the ones count.
module sd_channel_scheduler #(
    parameter int NCH    = 4,
    parameter int OSR    = 64,
    parameter int SETTLE = 4,
    parameter int CHW    = $clog2(NCH),
    parameter int CW     = $clog2(OSR + 1)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic [NCH-1:0] ch_en,
    output logic [CHW-1:0] mod_sel,
    output logic           mod_clr,
    output logic           mod_en,
    input  logic           mod_bit,
    output logic [CW:0]    out_data,
    output logic [CHW-1:0] out_ch,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           busy
);
    localparam int KW = $clog2(OSR + SETTLE + 1);
    typedef enum logic [2:0] {S_IDLE, S_SELECT, S_SETTLE, S_CONVERT, S_OUTPUT} state_t;
    state_t state_q, state_d;
    logic [KW-1:0] cyc_q, cyc_d;
    logic [CW-1:0] ones_q, ones_d, ones_total;
    logic [CHW-1:0] last_q, last_d, mod_sel_q, mod_sel_d, out_ch_q, out_ch_d, pick, idx;
    logic [CW:0] out_data_q, out_data_d, result;
    logic mod_clr_q, mod_clr_d, mod_en_q, mod_en_d, out_valid_q, out_valid_d, busy_q, busy_d;
    logic last_cyc, fin;
    assign ones_total = ones_q + CW'(mod_bit);
`ifdef SD_SCHED_BIPOLAR_EN
    localparam logic [CW:0] OSR_W = (CW + 1)'(OSR);
    assign result = {ones_total, 1'b0} - OSR_W;
`else
    assign result = {1'b0, ones_total};
`endif
    assign mod_sel   = mod_sel_q;
    assign mod_clr   = mod_clr_q;
    assign mod_en    = mod_en_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cyc_q       <= '0;
            ones_q      <= '0;
            last_q      <= CHW'(NCH - 1);
            mod_sel_q   <= '0;
            mod_clr_q   <= 1'b0;
            mod_en_q    <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            ones_q      <= ones_d;
            last_q      <= last_d;
            mod_sel_q   <= mod_sel_d;
            mod_clr_q   <= mod_clr_d;
            mod_en_q    <= mod_en_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end
    // next state: settle and convert phases end on their cycle budget
    always_comb begin
        state_d  = state_q;
        last_cyc = (state_q == S_SETTLE) ? (cyc_q == KW'(SETTLE - 1)) : (cyc_q == KW'(OSR - 1));
        case (state_q)
            S_IDLE:    state_d = (run && |ch_en) ? S_SELECT : S_IDLE;
            S_SELECT:  state_d = |ch_en ? S_SETTLE : S_IDLE;
            S_SETTLE:  state_d = last_cyc ? S_CONVERT : S_SETTLE;
            S_CONVERT: state_d = last_cyc ? S_OUTPUT : S_CONVERT;
            S_OUTPUT:  state_d = !out_ready ? S_OUTPUT : (run ? S_SELECT : S_IDLE);
            default:   state_d = S_IDLE;
        endcase
    end
    // outputs and datapath: round-robin pick, ones counting, result capture
    always_comb begin
        pick = last_q;
        idx  = last_q;
        for (int k = NCH; k >= 1; k--) begin
            idx = CHW'((int'(last_q) + k) % NCH);
            if (ch_en[idx]) pick = idx;
        end
        fin         = (state_q == S_CONVERT) && last_cyc;
        cyc_d       = (state_d == state_q) ? cyc_q + KW'(1) : '0;
        ones_d      = (state_q == S_SETTLE) ? '0 : (state_q == S_CONVERT) ? ones_total : ones_q;
        mod_sel_d   = (state_q == S_SELECT && |ch_en) ? pick : mod_sel_q;
        last_d      = (state_q == S_SELECT && |ch_en) ? pick : last_q;
        out_data_d  = fin ? result : out_data_q;
        out_ch_d    = fin ? mod_sel_q : out_ch_q;
        out_valid_d = state_d == S_OUTPUT;
        mod_clr_d   = state_d == S_SETTLE;
        mod_en_d    = state_d == S_CONVERT;
        busy_d      = state_d != S_IDLE;
    end
endmodule

// File: tb/tb_sd_channel_scheduler.sv
// tb_sd_channel_scheduler: randomized and directed checks against a timeline-based reference model.
module tb_sd_channel_scheduler;
    localparam int NCH = 4, OSR = 64, SETTLE = 4;
    localparam int CHW = $clog2(NCH), CW = $clog2(OSR + 1);
    logic clk = 0, reset = 0, run = 1, mod_bit = 0, out_ready = 1;
    logic [NCH-1:0] ch_en = 4'hF;
    logic [CHW-1:0] mod_sel, out_ch;
    logic mod_clr, mod_en, out_valid, busy;
    logic [CW:0] out_data;
    int errors = 0, checks = 0;
    int bit_mode = 1, ready_mode = 0;
    bit wild = 0, alt = 0, started = 0, pv = 0, found = 0;
    int ncyc = 0;
    int vq[$], cq[$];
    int m_phase = 0, m_t = 0, m_ones = 0, m_last = NCH - 1, m_sel = 0, m_och = 0;
    logic [CW:0] m_data = 0;

    sd_channel_scheduler #(.NCH(NCH), .OSR(OSR), .SETTLE(SETTLE)) dut (
        .clk(clk), .reset(reset), .run(run), .ch_en(ch_en), .mod_sel(mod_sel), .mod_clr(mod_clr),
        .mod_en(mod_en), .mod_bit(mod_bit), .out_data(out_data), .out_ch(out_ch),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [CW:0] conv(input int ones);
`ifdef SD_SCHED_BIPOLAR_EN
        return (CW + 1)'(2 * ones - OSR);
`else
        return (CW + 1)'(ones);
`endif
    endfunction

    // reference model: phase 0 idle, 1 select, 2 conversion timeline t, 3 result held
    always @(posedge clk) begin
        started = 1;
        if (!reset) begin
            m_phase = 0; m_t = 0; m_ones = 0; m_last = NCH - 1; m_sel = 0; m_och = 0; m_data = 0;
        end else begin
            case (m_phase)
                0: if (run && ch_en != 0) m_phase = 1;
                1: if (ch_en == 0) m_phase = 0;
                   else begin
                       found = 0;
                       for (int o = 1; o <= NCH; o++)
                           if (!found && ch_en[(m_last + o) % NCH]) begin
                               found = 1;
                               m_sel = (m_last + o) % NCH;
                           end
                       m_last = m_sel; m_t = 0; m_ones = 0; m_phase = 2;
                   end
                2: begin
                    if (m_t >= SETTLE && mod_bit) m_ones++;
                    if (m_t == SETTLE + OSR - 1) begin
                        m_data = conv(m_ones); m_och = m_sel; m_phase = 3;
                    end else m_t++;
                end
                default: if (out_ready) m_phase = run ? 1 : 0;
            endcase
        end
    end

    // per-cycle comparison against the model plus result-event recording
    always @(negedge clk) if (started) begin
        check("mod_sel", mod_sel, m_sel);
        check("mod_clr", mod_clr, m_phase == 2 && m_t < SETTLE);
        check("mod_en", mod_en, m_phase == 2 && m_t >= SETTLE);
        check("out_valid", out_valid, m_phase == 3);
        check("out_data", out_data, m_data);
        check("out_ch", out_ch, m_och);
        check("busy", busy, m_phase != 0);
        if (out_valid && !pv) begin
            vq.push_back(ncyc);
            cq.push_back(int'(out_ch));
        end
        pv = out_valid;
        ncyc++;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            alt = ~alt;
            mod_bit = bit_mode == 0 ? 1'b0 : bit_mode == 1 ? 1'b1 : bit_mode == 2 ? alt : 1'($urandom);
            out_ready = ready_mode == 0 ? 1'b1 : ready_mode == 2 ? 1'b0 : 1'($urandom);
            if (wild) begin
                run = ($urandom % 8) != 0;
                if ($urandom % 40 == 0) ch_en = NCH'($urandom);
                reset = ($urandom % 1500) != 0;
            end
        end
    endtask

    initial begin
        cyc(5);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        reset = 1; vq.delete(); cq.delete();
        cyc(5 * 70 + 20);
        check("n_results", vq.size() >= 5, 1);
        if (vq.size() >= 5) begin
            check("spacing", vq[1] - vq[0], 70);
            check("spacing2", vq[4] - vq[3], 70);
            for (int i = 0; i < 5; i++) check("ch_seq", cq[i], i % 4);
        end
        bit_mode = 2;
        cyc(3 * 70);
        ch_en = 4'b0101; bit_mode = 0; vq.delete(); cq.delete();
        cyc(5 * 70 + 10);
        check("n_results_0101", vq.size() >= 5, 1);
        if (vq.size() >= 5) for (int i = 2; i < 5; i++) check("ch_alt", cq[i] + cq[i-1], 2);
        ch_en = 4'b0000;
        cyc(150);
        check("idle_no_en", busy, 0);
        ch_en = 4'hF; ready_mode = 2; bit_mode = 3;
        for (int i = 0; i < 300 && !out_valid; i++) cyc(1);
        check("bp_reach", out_valid, 1);
        cyc(100);
        check("bp_hold", out_valid, 1);
        check("bp_en", mod_en, 0);
        ready_mode = 0; out_ready = 1;
        cyc(2);
        check("bp_next_clr", mod_clr, 1);
        for (int i = 0; i < 300 && !mod_en; i++) cyc(1);
        check("stop_reach", mod_en, 1);
        cyc(10);
        run = 0; vq.delete();
        cyc(150);
        check("stop_one", vq.size(), 1);
        check("stop_idle", busy, 0);
        run = 1;
        for (int i = 0; i < 300 && !mod_en; i++) cyc(1);
        check("rst_reach", mod_en, 1);
        cyc(10);
        reset = 0; run = 0; vq.delete();
        cyc(1);
        reset = 1;
        cyc(100);
        check("rst_noresult", vq.size(), 0);
        check("rst_idle", busy, 0);
        run = 1; wild = 1; bit_mode = 3; ready_mode = 1;
        cyc(4000);
        wild = 0; reset = 1; run = 1; ch_en = 4'hF; ready_mode = 0; vq.delete();
        cyc(200);
        check("final_results", vq.size() >= 2, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sd_channel_scheduler.md
# sd_channel_scheduler

Time-multiplexes one first-order sigma-delta oversampling modulator across up to NCH analog input channels. The block selects channels round-robin, clears and settles the modulator after each switch, enables it for exactly OSR cycles while counting ones in its 1-bit output (sinc1 decimation), and then presents the result with its channel tag on a valid/ready output. It sits between the analog input mux and modulator on one side and the sample consumer (filter/FIFO) on the other.

## Interface
- NCH, 4, number of channels (2..16)
- OSR, 64, modulator cycles per conversion (≥2)
- SETTLE, 4, modulator-clear cycles after a channel switch (≥1)
- CHW, $clog2(NCH), channel index width (derived)
- CW, $clog2(OSR+1), ones-count width (derived)
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-low reset
- run  in  1  level; 1 = keep converting
- ch_en  in  NCH  per-channel enable mask
- mod_sel  out  CHW  analog mux select to modulator
- mod_clr  out  1  clears modulator integrator/feedback
- mod_en  out  1  modulator enable; mod_bit counted while high
- mod_bit  in  1  modulator comparator output, valid in any cycle mod_en=1
- out_data  out  CW+1  conversion result (see Configuration)
- out_ch  out  CHW  channel of out_data
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts when out_valid & out_ready
- busy  out  1  state != IDLE

## Operation
- States: IDLE, SELECT, SETTLE, CONVERT, OUTPUT.
- IDLE: go to SELECT when run=1 and ch_en != 0; otherwise stay.
- SELECT (1 cycle): if ch_en == 0, go IDLE. Otherwise pick the first enabled channel searching from last+1 modulo NCH; register into mod_sel and last; go SETTLE.
- SETTLE: mod_clr=1 for exactly SETTLE cycles; ones counter cleared; go CONVERT.
- CONVERT: mod_en=1 for exactly OSR cycles; counter increments on every cycle with mod_bit=1; on the last cycle the final count (including that cycle's mod_bit) is registered into out_data, out_ch=mod_sel; go OUTPUT.
- OUTPUT: out_valid=1 until handshake. On handshake: go SELECT if run=1, else IDLE.
- ch_en is sampled only in SELECT; changes during SETTLE/CONVERT/OUTPUT do not abort the current conversion. A channel disabled mid-conversion still delivers its result.
- run=0 mid-conversion: current conversion completes and is delivered, then IDLE.
- Counter is CW bits; maximum value OSR, never wraps.
- Reset values: mod_sel=0, mod_clr=0, mod_en=0, out_data=0, out_ch=0, out_valid=0, busy=0, last=NCH-1 (first selected channel after reset is the lowest enabled index ≥0).

## Timing
- All outputs registered; mod_clr/mod_en asserted in the cycles the FSM is in SETTLE/CONVERT.
- run sampled high in IDLE at edge N: SELECT during cycle N+1, SETTLE N+2..N+1+SETTLE, CONVERT next OSR cycles, out_valid in the following cycle.
- Per-conversion minimum period with out_ready=1: 1 + SETTLE + OSR + 1 cycles (70 with defaults).
- Backpressure: while out_valid=1 and out_ready=0, out_data/out_ch/mod_sel stable, mod_en=0, mod_clr=0; no new conversion starts.
- Handshake completes in the cycle out_valid & out_ready; out_valid drops next cycle.
- reset=0 at any edge, any state: next cycle all outputs at reset values, in-flight result discarded.

## Configuration
- SD_SCHED_BIPOLAR_EN defined: out_data = 2*ones − OSR, two's complement, CW+1 bits (range −OSR..+OSR).
- Not defined: out_data = ones count zero-extended to CW+1 bits (range 0..OSR).

## Test plan
- Reset: hold reset=0 with run=1, ch_en=4'hF -> all outputs 0, busy=0; release -> first out_ch=0.
- ch_en=4'hF, run=1, mod_bit=1, out_ready=1 -> out_ch sequence 0,1,2,3,0; out_data=64 (bipolar +64); out_valid spacing 70 cycles.
- mod_bit alternating 1/0 during CONVERT -> out_data=32 (bipolar 0); mod_en high exactly 64 cycles, mod_clr exactly 4.
- ch_en=4'b0101, mod_bit=0 -> out_ch 0,2,0,2; out_data=0 (bipolar −64); ch_en=0 in SELECT -> IDLE, busy=0.
- out_ready=0 for 100 cycles at OUTPUT -> out_valid, out_data, out_ch, mod_sel stable, mod_en=0; out_ready=1 -> next channel's SELECT follows.
- reset=0 mid-CONVERT, and separately run=0 mid-CONVERT -> former: outputs zero next cycle, no result; latter: result delivered, then IDLE.
